// File: rtl/mem_port_arbiter_if.sv
// Bundle between the core's fetch/MW stages, the arbiter and the memory wrapper.
// fsm_state and starve_cnt are read-only debug views of the arbiter's internal state.
interface mem_port_arbiter_if #(
    parameter int Width = 32
) ();
    // Handshake: a requester raises *_req with stable operands and holds it until
    // the one-cycle *_ack; memory sees a level mem_req held until mem_valid.
    logic             if_req;
    logic [Width-1:0] if_addr;
    logic             if_ack;
    logic [Width-1:0] if_rdata;

    logic             dm_req;
    logic             dm_we;
    logic [3:0]       dm_mask;
    logic [Width-1:0] dm_addr;
    logic [Width-1:0] dm_wdata;
    logic             dm_ack;
    logic [Width-1:0] dm_rdata;

    logic             flush;

    logic             mem_req;
    logic             mem_we;
    logic [3:0]       mem_mask;
    logic [Width-1:0] mem_addr;
    logic [Width-1:0] mem_wdata;
    logic [Width-1:0] mem_rdata;
    logic             mem_valid;

    logic             stall;
    logic             err;

    logic [1:0]       fsm_state;
    logic [3:0]       starve_cnt;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_mask, dm_addr, dm_wdata, flush,
               mem_rdata, mem_valid,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_mask,
               mem_addr, mem_wdata, stall, err, fsm_state, starve_cnt
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_mask, dm_addr, dm_wdata, flush,
               mem_rdata, mem_valid,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_mask,
               mem_addr, mem_wdata, stall, err, fsm_state, starve_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data accesses onto one variable-latency memory port.
// Define MEM_TIMEOUT_EN to abort accesses after Timeout wait cycles and pulse err.
module mem_port_arbiter #(
    parameter int Width       = 32,
    parameter int StarveLimit = 4,
    parameter int Timeout     = 64
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        IF_DROP = 2'd3
    } state_t;

    if (StarveLimit < 1 || StarveLimit > 15 || Timeout < 2) begin : g_param_check
        $error("mem_port_arbiter: StarveLimit must be 1..15 and Timeout at least 2");
    end

    state_t           state;
    state_t           state_next;
    logic [3:0]       starve_cnt;
    logic             if_elig;
    logic             dm_elig;
    logic             grant_if;
    logic             grant_dm;
    logic             busy;
    logic             timeout;
    logic             if_ack_set;
    logic             dm_ack_set;
    logic             if_ack;
    logic             dm_ack;
    logic [Width-1:0] if_rdata;
    logic [Width-1:0] dm_rdata;
    logic [Width-1:0] addr_q;
    logic [Width-1:0] wdata_q;
    logic             we_q;
    logic [3:0]       mask_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant_dm)      state_next = DM_BUSY;
                else if (grant_if) state_next = IF_BUSY;
            end
            // A response arriving with flush is dropped by if_ack_set, not by the state.
            IF_BUSY: begin
                if (bus.mem_valid || timeout) state_next = IDLE;
                else if (bus.flush)           state_next = IF_DROP;
            end
            DM_BUSY, IF_DROP: begin
                if (bus.mem_valid || timeout) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        if_elig  = bus.if_req & ~if_ack & ~bus.flush;
        dm_elig  = bus.dm_req & ~dm_ack;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE) begin
            grant_if = if_elig & (~dm_elig | (starve_cnt == 4'(StarveLimit)));
            grant_dm = dm_elig & ~grant_if;
        end
        busy       = (state != IDLE);
        if_ack_set = (state == IF_BUSY) & ~bus.flush & (bus.mem_valid | timeout);
        dm_ack_set = (state == DM_BUSY) & (bus.mem_valid | timeout);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            mask_q     <= '0;
            starve_cnt <= '0;
        end else begin
            if_ack <= if_ack_set;
            dm_ack <= dm_ack_set;
            if (if_ack_set) if_rdata <= timeout ? '0 : bus.mem_rdata;
            // Stores leave dm_rdata alone unless the access was aborted.
            if (dm_ack_set && (timeout || !we_q)) dm_rdata <= timeout ? '0 : bus.mem_rdata;
            if (grant_if) begin
                addr_q  <= bus.if_addr;
                wdata_q <= '0;
                we_q    <= 1'b0;
                mask_q  <= '0;
            end else if (grant_dm) begin
                addr_q  <= bus.dm_addr;
                wdata_q <= bus.dm_wdata;
                we_q    <= bus.dm_we;
                mask_q  <= bus.dm_mask;
            end
            if (grant_if) begin
                starve_cnt <= '0;
            end else if (grant_dm && bus.if_req && !if_ack &&
                         starve_cnt != 4'(StarveLimit)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int WaitW = $clog2(Timeout) + 1;

    logic [WaitW-1:0] wait_cnt;
    logic             err;

    assign timeout = busy & ~bus.mem_valid & (wait_cnt == WaitW'(Timeout - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= timeout;
            if (!busy || state_next != state) wait_cnt <= '0;
            else if (!bus.mem_valid)          wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign bus.err = err;
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign bus.mem_req    = busy;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_mask   = mask_q;
    assign bus.if_ack     = if_ack;
    assign bus.dm_ack     = dm_ack;
    assign bus.if_rdata   = if_rdata;
    assign bus.dm_rdata   = dm_rdata;
    assign bus.stall      = (bus.if_req & ~if_ack) | (bus.dm_req & ~dm_ack);
    assign bus.fsm_state  = state;
    assign bus.starve_cnt = starve_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, arbitration, starvation,
// flush, store, timeout (MEM_TIMEOUT_EN) or indefinite wait, and reset mid-access.
module tb_mem_port_arbiter;
`ifdef MEM_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 64;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    mem_port_arbiter_if #(.Width(32)) bus ();

    mem_port_arbiter #(
        .Width      (32),
        .StarveLimit(4),
        .Timeout    (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_mask   = '0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.flush     = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_valid = 1'b0;
        tick();
        tick();

        check("rst_state",     32'(bus.fsm_state), 32'd0);
        check("rst_mem_req",   32'(bus.mem_req),   32'd0);
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mem_mask",  32'(bus.mem_mask),  32'd0);
        check("rst_mem_addr",  bus.mem_addr,       32'd0);
        check("rst_mem_wdata", bus.mem_wdata,      32'd0);
        check("rst_if_ack",    32'(bus.if_ack),    32'd0);
        check("rst_dm_ack",    32'(bus.dm_ack),    32'd0);
        check("rst_if_rdata",  bus.if_rdata,       32'd0);
        check("rst_dm_rdata",  bus.dm_rdata,       32'd0);
        check("rst_stall",     32'(bus.stall),     32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        check("rst_starve",    32'(bus.starve_cnt), 32'd0);
        rst_n = 1'b1;

        // Fetch alone: ack two cycles after the request.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        #1;
        check("f_stall_c0", 32'(bus.stall), 32'd1);
        tick();
        check("f_state_c1",   32'(bus.fsm_state), 32'd1);
        check("f_mem_req_c1", 32'(bus.mem_req),   32'd1);
        check("f_mem_addr",   bus.mem_addr,       32'h100);
        check("f_mem_we",     32'(bus.mem_we),    32'd0);
        check("f_stall_c1",   32'(bus.stall),     32'd1);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h00500093;
        tick();
        check("f_if_ack_c2",   32'(bus.if_ack),    32'd1);
        check("f_if_rdata",    bus.if_rdata,       32'h00500093);
        check("f_mem_req_c2",  32'(bus.mem_req),   32'd0);
        check("f_state_c2",    32'(bus.fsm_state), 32'd0);
        check("f_stall_c2",    32'(bus.stall),     32'd0);
        bus.if_req    = 1'b0;
        bus.mem_valid = 1'b0;
        tick();
        check("f_if_ack_c3", 32'(bus.if_ack), 32'd0);

        // Simultaneous: data first, fetch in the ack cycle's IDLE.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h104;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h2000;
        tick();
        check("s_state_dm",  32'(bus.fsm_state),  32'd2);
        check("s_mem_addr1", bus.mem_addr,        32'h2000);
        check("s_starve1",   32'(bus.starve_cnt), 32'd1);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h11223344;
        tick();
        check("s_dm_ack",    32'(bus.dm_ack), 32'd1);
        check("s_dm_rdata",  bus.dm_rdata,    32'h11223344);
        bus.mem_valid = 1'b0;
        bus.dm_req    = 1'b0;
        tick();
        check("s_state_if",  32'(bus.fsm_state),  32'd1);
        check("s_mem_addr2", bus.mem_addr,        32'h104);
        check("s_starve0",   32'(bus.starve_cnt), 32'd0);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hAAAA0001;
        tick();
        check("s_if_ack",    32'(bus.if_ack), 32'd1);
        check("s_if_rdata",  bus.if_rdata,    32'hAAAA0001);
        bus.mem_valid = 1'b0;
        bus.if_req    = 1'b0;
        tick();

        // Starvation: flush in each dm ack cycle keeps fetch out of the lone-requester IDLE.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            bus.dm_req  = 1'b1;
            bus.dm_we   = 1'b0;
            bus.dm_addr = 32'h3000 + 32'(i) * 4;
            tick();
            if (i < 4) begin
                check("st_state_dm", 32'(bus.fsm_state),  32'd2);
                check("st_starve",   32'(bus.starve_cnt), 32'(i + 1));
                check("st_addr_dm",  bus.mem_addr,        32'h3000 + 32'(i) * 4);
                bus.mem_rdata = 32'h50000000 + 32'(i);
            end else begin
                check("st_state_if", 32'(bus.fsm_state),  32'd1);
                check("st_starve0",  32'(bus.starve_cnt), 32'd0);
                check("st_addr_if",  bus.mem_addr,        32'h200);
                bus.mem_rdata = 32'h12345678;
            end
            bus.mem_valid = 1'b1;
            tick();
            bus.mem_valid = 1'b0;
            if (i < 4) begin
                check("st_dm_ack",   32'(bus.dm_ack), 32'd1);
                check("st_dm_rdata", bus.dm_rdata,    32'h50000000 + 32'(i));
                bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
                check("st_idle", 32'(bus.fsm_state), 32'd0);
            end else begin
                check("st_if_ack",   32'(bus.if_ack), 32'd1);
                check("st_if_rdata", bus.if_rdata,    32'h12345678);
            end
        end
        bus.if_req = 1'b0;
        tick();
        check("st_tail_state",  32'(bus.fsm_state),  32'd2);
        check("st_tail_addr",   bus.mem_addr,        32'h3010);
        check("st_tail_starve", 32'(bus.starve_cnt), 32'd0);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h66660000;
        tick();
        check("st_tail_ack",   32'(bus.dm_ack), 32'd1);
        check("st_tail_rdata", bus.dm_rdata,    32'h66660000);
        bus.mem_valid = 1'b0;
        bus.dm_req    = 1'b0;
        tick();

        // Flush in the second IF_BUSY cycle; response three cycles later is dropped.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        tick();
        check("fl_state_c1", 32'(bus.fsm_state), 32'd1);
        tick();
        check("fl_state_c2", 32'(bus.fsm_state), 32'd1);
        bus.flush  = 1'b1;
        bus.if_req = 1'b0;
        tick();
        check("fl_drop_state", 32'(bus.fsm_state), 32'd3);
        check("fl_drop_req",   32'(bus.mem_req),   32'd1);
        check("fl_drop_addr",  bus.mem_addr,       32'h300);
        bus.flush = 1'b0;
        tick();
        bus.flush = 1'b1;
        tick();
        check("fl_drop_hold", 32'(bus.fsm_state), 32'd3);
        bus.flush     = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hBADBAD00;
        tick();
        check("fl_end_state",  32'(bus.fsm_state), 32'd0);
        check("fl_no_ack",     32'(bus.if_ack),    32'd0);
        check("fl_rdata_keep", bus.if_rdata,       32'h12345678);
        check("fl_end_req",    32'(bus.mem_req),   32'd0);
        bus.mem_valid = 1'b0;

        // Flush in the same cycle as mem_valid.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h304;
        tick();
        check("fv_state", 32'(bus.fsm_state), 32'd1);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        bus.flush     = 1'b1;
        bus.if_req    = 1'b0;
        tick();
        check("fv_idle",   32'(bus.fsm_state), 32'd0);
        check("fv_no_ack", 32'(bus.if_ack),    32'd0);
        check("fv_rdata",  bus.if_rdata,       32'h12345678);
        bus.mem_valid = 1'b0;
        bus.flush     = 1'b0;
        tick();
        check("fv_no_ack2", 32'(bus.if_ack), 32'd0);

        // Store with a flush during DM_BUSY, then mem_valid seen in IDLE.
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_mask  = 4'b0011;
        bus.dm_addr  = 32'h4000;
        bus.dm_wdata = 32'hDEADBEEF;
        tick();
        check("sw_state", 32'(bus.fsm_state), 32'd2);
        check("sw_we",    32'(bus.mem_we),    32'd1);
        check("sw_mask",  32'(bus.mem_mask),  32'd3);
        check("sw_wdata", bus.mem_wdata,      32'hDEADBEEF);
        check("sw_addr",  bus.mem_addr,       32'h4000);
        check("sw_stall", 32'(bus.stall),     32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("sw_hold_state", 32'(bus.fsm_state), 32'd2);
        check("sw_hold_req",   32'(bus.mem_req),   32'd1);
        check("sw_hold_we",    32'(bus.mem_we),    32'd1);
        check("sw_hold_wdata", bus.mem_wdata,      32'hDEADBEEF);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h99999999;
        tick();
        check("sw_ack",     32'(bus.dm_ack),  32'd1);
        check("sw_rdata",   bus.dm_rdata,     32'h66660000);
        check("sw_req_end", 32'(bus.mem_req), 32'd0);
        bus.dm_req  = 1'b0;
        bus.dm_we   = 1'b0;
        bus.dm_mask = 4'b0000;
        tick();
        check("iv_state",  32'(bus.fsm_state), 32'd0);
        check("iv_dm_ack", 32'(bus.dm_ack),    32'd0);
        check("iv_if_ack", 32'(bus.if_ack),    32'd0);
        bus.mem_valid = 1'b0;

        // Load with no response.
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h6000;
        tick();
        check("to_state", 32'(bus.fsm_state), 32'd2);
`ifdef MEM_TIMEOUT_EN
        for (int k = 2; k <= 8; k++) begin
            tick();
            check("to_wait_req", 32'(bus.mem_req), 32'd1);
            check("to_wait_err", 32'(bus.err),     32'd0);
        end
        tick();
        check("to_err",    32'(bus.err),       32'd1);
        check("to_ack",    32'(bus.dm_ack),    32'd1);
        check("to_rdata",  bus.dm_rdata,       32'd0);
        check("to_idle",   32'(bus.fsm_state), 32'd0);
        check("to_req",    32'(bus.mem_req),   32'd0);
        bus.dm_req = 1'b0;
        tick();
        check("to_err_end", 32'(bus.err),    32'd0);
        check("to_ack_end", 32'(bus.dm_ack), 32'd0);
`else
        for (int k = 0; k < 10; k++) begin
            tick();
            check("nw_wait_req", 32'(bus.mem_req), 32'd1);
            check("nw_wait_err", 32'(bus.err),     32'd0);
        end
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h77770000;
        tick();
        check("nw_ack",   32'(bus.dm_ack), 32'd1);
        check("nw_rdata", bus.dm_rdata,    32'h77770000);
        bus.mem_valid = 1'b0;
        bus.dm_req    = 1'b0;
        tick();
`endif

        // Reset in the middle of DM_BUSY; a late mem_valid is ignored.
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h5000;
        tick();
        check("mr_state", 32'(bus.fsm_state), 32'd2);
        rst_n      = 1'b0;
        bus.dm_req = 1'b0;
        tick();
        check("mr_state0",  32'(bus.fsm_state), 32'd0);
        check("mr_req0",    32'(bus.mem_req),   32'd0);
        check("mr_addr0",   bus.mem_addr,       32'd0);
        check("mr_if_rd0",  bus.if_rdata,       32'd0);
        check("mr_dm_rd0",  bus.dm_rdata,       32'd0);
        check("mr_stall0",  32'(bus.stall),     32'd0);
        check("mr_err0",    32'(bus.err),       32'd0);
        rst_n         = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hFFFF0000;
        tick();
        check("mr_late_ack",   32'(bus.dm_ack),    32'd0);
        check("mr_late_state", 32'(bus.fsm_state), 32'd0);
        check("mr_late_rdata", bus.dm_rdata,       32'd0);
        bus.mem_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
